// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter.
// Video scan-out owns active pixel ticks; clients share the rest round-robin.
module vga_fb_arbiter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_tick,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              video_en,
  output logic [DATA_W-1:0] pixel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    ACK
  } state_t;

  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);

  state_t            state;
  state_t            state_nx;
  logic              prio_rd;
  logic              rd_oob;
  logic              tick_d;
  logic              vid_d;
  logic              vslot;
  logic              w_oob;
  logic              r_oob;
  logic              gnt_w;
  logic              gnt_r;
  logic [ADDR_W-1:0] vaddr;
  logic              unused_bits;

  assign unused_bits = ^{x[0], y[0]};

  // Slot classification, framebuffer address and client grant decision
  always_comb begin
    vslot = pix_tick & video_en;
    vaddr = ADDR_W'(y[9:1]) * ADDR_W'(FB_W) + ADDR_W'(x[9:1]);
    w_oob = ({1'b0, wr_addr} >= FB_SIZE);
    r_oob = ({1'b0, rd_addr} >= FB_SIZE);
    gnt_w = 1'b0;
    gnt_r = 1'b0;
    if (state == IDLE && !vslot) begin
      if (wr_req && (!rd_req || !prio_rd)) gnt_w = 1'b1;
      else if (rd_req)                     gnt_r = 1'b1;
    end
  end

  // Next-state logic and memory port mux (video wins, then grant, else idle)
  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_w)      state_nx = ACK;
        else if (gnt_r) state_nx = RD_WAIT;
      end
      RD_WAIT: state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (vslot) begin
      mem_addr = vaddr;
    end else if (gnt_w) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      mem_we    = !w_oob;
    end else if (gnt_r && !r_oob) begin
      mem_addr = rd_addr;
    end
  end

  // Client FSM state, round-robin flag, acks and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      prio_rd <= 1'b0;
      rd_oob  <= 1'b0;
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      state  <= state_nx;
      wr_ack <= gnt_w;
      rd_ack <= (state == RD_WAIT);
      if (gnt_w) prio_rd <= 1'b1;
      if (gnt_r) begin
        prio_rd <= 1'b0;
        rd_oob  <= r_oob;
      end
      if (state == RD_WAIT) rd_data <= rd_oob ? '0 : mem_rdata;
    end
  end

  // Video pipeline: RAM data of a tick lands in pixel one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d <= 1'b0;
      vid_d  <= 1'b0;
      pixel  <= '0;
    end else begin
      tick_d <= pix_tick;
      vid_d  <= vslot;
      if (tick_d) pixel <= vid_d ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of the framebuffer arbiter.
// Includes a synchronous single-port RAM model behind the memory port.
module tb_vga_fb_arbiter;

  logic        clk;
  logic        reset;
  logic        pix_tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_en;
  logic [7:0]  pixel;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;

  logic [7:0]  ram [0:131071];

  int checks;
  int errors;
  int seq[$];
  int vid_we;
  int dbl_ack;
  int rd_seen;
  logic prev_ack;

  vga_fb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .pix_tick  (pix_tick),
    .x         (x),
    .y         (y),
    .video_en  (video_en),
    .pixel     (pixel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [16:0] a, input logic [7:0] d);
    nxt(); wr_req = 1'b1; wr_addr = a; wr_data = d;
    nxt();
    nxt(); wr_req = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; pix_tick = 1'b0; x = '0; y = '0; video_en = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    #3;
    chk("rst_pixel", pixel, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    nxt(); nxt(); reset = 1'b0;

    // write 0xA5 to address 0 during blanking
    nxt(); wr_req = 1'b1; wr_addr = 17'd0; wr_data = 8'hA5; #1;
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 0);
    chk("wr_wdata", mem_wdata, 8'hA5);
    nxt();
    chk("wr_ack", wr_ack, 1);
    chk("ack_no_we", mem_we, 0);
    nxt(); wr_req = 1'b0; #1;
    chk("wr_ack_pulse", wr_ack, 0);

    // video slot at (0,0) shows 0xA5 two cycles later
    nxt(); pix_tick = 1'b1; video_en = 1'b1; x = 10'd0; y = 10'd0; #1;
    chk("vid_addr0", mem_addr, 0);
    chk("vid_we0", mem_we, 0);
    nxt(); pix_tick = 1'b0; #1;
    chk("pix_lat1", pixel, 0);
    nxt();
    chk("pix_lat2", pixel, 8'hA5);

    // bottom-right address, then blanked tick clears pixel
    nxt(); pix_tick = 1'b1; x = 10'd639; y = 10'd479; #1;
    chk("vid_addr_max", mem_addr, 76799);
    nxt(); pix_tick = 1'b0; x = 10'd0; y = 10'd0;
    nxt(); pix_tick = 1'b1; video_en = 1'b0;
    nxt(); pix_tick = 1'b0; #1;
    nxt();
    chk("pix_blank", pixel, 0);

    // read latency
    do_write(17'd100, 8'h3C);
    nxt(); rd_req = 1'b1; rd_addr = 17'd100; #1;
    chk("rd_addr", mem_addr, 100);
    chk("rd_no_we", mem_we, 0);
    nxt();
    chk("rd_ack_early", rd_ack, 0);
    nxt();
    chk("rd_ack", rd_ack, 1);
    chk("rd_data", rd_data, 8'h3C);
    nxt(); rd_req = 1'b0; #1;
    chk("rd_ack_pulse", rd_ack, 0);
    chk("rd_data_hold", rd_data, 8'h3C);

    // out-of-range write and read
    nxt(); wr_req = 1'b1; wr_addr = 17'd76800; wr_data = 8'h77; #1;
    chk("oob_wr_we", mem_we, 0);
    nxt();
    chk("oob_wr_ack", wr_ack, 1);
    nxt(); wr_req = 1'b0;
    nxt(); rd_req = 1'b1; rd_addr = 17'd76800;
    nxt(); nxt();
    chk("oob_rd_ack", rd_ack, 1);
    chk("oob_rd_data", rd_data, 0);
    nxt(); rd_req = 1'b0;
    nxt();

    // contention during active video
    video_en = 1'b1; x = 10'd0; y = 10'd0;
    vid_we = 0; dbl_ack = 0; prev_ack = 1'b0;
    wr_addr = 17'd200; wr_data = 8'h11; rd_addr = 17'd100;
    for (int i = 0; i < 30; i++) begin
      nxt();
      pix_tick = ~pix_tick; wr_req = 1'b1; rd_req = 1'b1; #1;
      if (pix_tick && mem_we) vid_we++;
      if (wr_ack) seq.push_back(0);
      if (rd_ack) seq.push_back(1);
      if (prev_ack && (wr_ack || rd_ack)) dbl_ack++;
      prev_ack = wr_ack | rd_ack;
    end
    nxt(); wr_req = 1'b0; rd_req = 1'b0; pix_tick = 1'b0;
    chk("cont_vid_we", vid_we, 0);
    chk("cont_dbl_ack", dbl_ack, 0);
    chk("cont_count", seq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      chk($sformatf("cont_order%0d", i), seq[i], i % 2);
    nxt(); nxt(); nxt(); nxt();

    // reset in RD_WAIT
    nxt(); video_en = 1'b0; rd_req = 1'b1; rd_addr = 17'd100; #1;
    chk("mr_grant", mem_addr, 100);
    nxt(); #2; reset = 1'b1; #1;
    chk("mr_pixel", pixel, 0);
    chk("mr_rd_data", rd_data, 0);
    chk("mr_rd_ack", rd_ack, 0);
    chk("mr_mem_we", mem_we, 0);
    rd_req = 1'b0;
    rd_seen = 0;
    nxt(); nxt(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (rd_ack) rd_seen++;
    end
    chk("mr_no_ack", rd_seen, 0);
    nxt(); wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 17'd300; wr_data = 8'h55; rd_addr = 17'd100; #1;
    chk("mr_prio_we", mem_we, 1);
    chk("mr_prio_addr", mem_addr, 300);
    nxt();
    chk("mr_wr_ack", wr_ack, 1);
    nxt(); wr_req = 1'b0; rd_req = 1'b0;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
